// File: rtl/pocket_lab_pkg.sv
// Shared constants, parser states and helpers for the pocket lab controller.
// Holds frame bytes, reset defaults and the divider clamp.
package pocket_lab_pkg;
  localparam logic [7:0] HDR         = 8'h5A;
  localparam logic [7:0] OP_CFG      = 8'h01;
  localparam int         PAYLOAD_LEN = 8;
  localparam logic [7:0] TX_RESET    = 8'hA5;

  localparam logic [7:0] DFLT_ADC_DIV    = 8'd2;
  localparam logic [7:0] DFLT_DAC_DIV    = 8'd2;
  localparam logic [7:0] DFLT_TRIG_LEVEL = 8'h80;
  localparam logic [7:0] DFLT_PATTERN    = 8'h80;

  typedef enum logic [1:0] {
    HUNT,
    OPCODE,
    PAYLOAD
  } parse_t;

  // A divider of zero behaves as one.
  function automatic logic [7:0] div_eff(
    input logic [7:0] d
  );
    return (d == 8'd0) ? 8'd1 : d;
  endfunction
endpackage

// File: rtl/spi_byte_slave.sv
// SPI slave byte engine: synchronisers, LSB-first rx/tx, idle resync.
// Ports: clk/rst, spi_* pins, cs_on (synced cs), byte_valid/byte_data.
module spi_byte_slave
  import pocket_lab_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  input  logic       spi_cs,
  output logic       spi_miso,
  output logic       cs_on,
  output logic       byte_valid,
  output logic [7:0] byte_data
);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_TIMEOUT - 1);

  logic [1:0]    clk_sy;
  logic [1:0]    mosi_sy;
  logic [1:0]    cs_sy;
  logic          clk_q;
  logic [2:0]    bit_cnt;
  logic [2:0]    tx_idx;
  logic [7:0]    rx_sh;
  logic [7:0]    tx_byte;
  logic [IW-1:0] idle;
  logic          fall;
  logic          rise;
  logic [7:0]    rx_next;

  assign cs_on   = cs_sy[1];
  assign fall    = clk_q & ~clk_sy[1];
  assign rise    = clk_sy[1] & ~clk_q;
  assign rx_next = {mosi_sy[1], rx_sh[7:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sy     <= '0;
      mosi_sy    <= '0;
      cs_sy      <= '0;
      clk_q      <= 1'b0;
      bit_cnt    <= '0;
      tx_idx     <= '0;
      rx_sh      <= '0;
      tx_byte    <= TX_RESET;
      idle       <= '0;
      spi_miso   <= 1'b0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
    end else begin
      clk_sy     <= {clk_sy[0], spi_clk};
      mosi_sy    <= {mosi_sy[0], spi_mosi};
      cs_sy      <= {cs_sy[0], spi_cs};
      clk_q      <= clk_sy[1];
      byte_valid <= 1'b0;
      if (!cs_on) begin
        bit_cnt  <= '0;
        tx_idx   <= '0;
        idle     <= '0;
        spi_miso <= 1'b0;
      end else begin
        spi_miso <= tx_byte[tx_idx];
        if (rise) begin
          tx_idx <= tx_idx + 3'd1;
        end
        if (fall) begin
          rx_sh   <= rx_next;
          bit_cnt <= bit_cnt + 3'd1;
          idle    <= '0;
          if (bit_cnt == 3'd7) begin
            byte_valid <= 1'b1;
            byte_data  <= rx_next;
            tx_byte    <= rx_next;
            tx_idx     <= '0;
          end
        end else if (idle == IDLE_MAX) begin
          // Lost clocks: drop any partial byte.
          bit_cnt <= '0;
          tx_idx  <= '0;
          idle    <= '0;
        end else begin
          idle <= idle + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/pocket_lab_ctrl.sv
// Pocket lab top: SPI config parser, ADC/DAC clocks, capture, triggers.
// Ports: osc_27m/rst_key, adc_*, dac_*, spi_*, triggers[3:0].
module pocket_lab_ctrl
  import pocket_lab_pkg::*;
#(
  parameter int         IDLE_TIMEOUT   = 64,
  parameter logic [7:0] DEF_ADC_DIV    = DFLT_ADC_DIV,
  parameter logic [7:0] DEF_DAC_DIV    = DFLT_DAC_DIV,
  parameter logic [7:0] DEF_TRIG_LEVEL = DFLT_TRIG_LEVEL
) (
  input  logic       osc_27m,
  input  logic       rst_key,
  output logic       adc_clk,
  input  logic [7:0] adc_data,
  output logic       dac_clk,
  output logic [7:0] dac_data,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  input  logic       spi_cs,
  output logic [3:0] triggers
);
  logic       cs_on;
  logic       byte_valid;
  logic [7:0] byte_data;

  parse_t     st;
  logic [2:0] idx;
  logic [7:0] shadow [PAYLOAD_LEN];
  logic       apply;

  logic [7:0] trig_level;
  logic [7:0] trig_mode;
  logic [7:0] adc_div;
  logic [7:0] dac_div;
  logic [7:0] pattern [4];

  logic [7:0] adc_cnt;
  logic [7:0] dac_cnt;
  logic [1:0] dac_ptr;
  logic [7:0] adc_sample;
  logic       ge;
  logic       ge_q;
  logic       trig_lvl;
  logic       trig_cfg;
  logic       trig_hdr;
  logic       trig_byte;

  spi_byte_slave #(
    .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) u_spi (
    .clk       (osc_27m),
    .rst       (rst_key),
    .spi_clk   (spi_clk),
    .spi_mosi  (spi_mosi),
    .spi_cs    (spi_cs),
    .spi_miso  (spi_miso),
    .cs_on     (cs_on),
    .byte_valid(byte_valid),
    .byte_data (byte_data)
  );

  assign triggers = {trig_byte, trig_hdr, trig_cfg, trig_lvl};
  assign ge       = adc_sample >= trig_level;

  // Parser and config: payload lands in shadow, copied in one cycle.
  always_ff @(posedge osc_27m or posedge rst_key) begin
    if (rst_key) begin
      st         <= HUNT;
      idx        <= '0;
      apply      <= 1'b0;
      trig_cfg   <= 1'b0;
      trig_hdr   <= 1'b0;
      trig_level <= DEF_TRIG_LEVEL;
      trig_mode  <= '0;
      adc_div    <= DEF_ADC_DIV;
      dac_div    <= DEF_DAC_DIV;
      for (int i = 0; i < 4; i++) pattern[i] <= DFLT_PATTERN;
      for (int i = 0; i < PAYLOAD_LEN; i++) shadow[i] <= '0;
    end else begin
      apply    <= 1'b0;
      trig_cfg <= apply;
      trig_hdr <= 1'b0;
      if (apply) begin
        trig_level <= shadow[0];
        trig_mode  <= shadow[1];
        adc_div    <= shadow[2];
        dac_div    <= shadow[3];
        for (int i = 0; i < 4; i++) pattern[i] <= shadow[4+i];
      end
      if (!cs_on) begin
        st <= HUNT;
      end else if (byte_valid) begin
        unique case (st)
          HUNT: begin
            if (byte_data == HDR) begin
              st       <= OPCODE;
              trig_hdr <= 1'b1;
            end
          end
          OPCODE: begin
            if (byte_data == OP_CFG) begin
              st  <= PAYLOAD;
              idx <= '0;
            end else begin
              st <= HUNT;
            end
          end
          PAYLOAD: begin
            shadow[idx] <= byte_data;
            if (idx == 3'(PAYLOAD_LEN - 1)) begin
              apply <= 1'b1;
              st    <= HUNT;
            end else begin
              idx <= idx + 3'd1;
            end
          end
          default: st <= HUNT;
        endcase
      end
    end
  end

  always_ff @(posedge osc_27m or posedge rst_key) begin
    if (rst_key) begin
      adc_cnt    <= '0;
      dac_cnt    <= '0;
      adc_clk    <= 1'b0;
      dac_clk    <= 1'b0;
      dac_ptr    <= '0;
      dac_data   <= DFLT_PATTERN;
      adc_sample <= '0;
    end else if (apply) begin
      adc_cnt <= '0;
      dac_cnt <= '0;
      dac_ptr <= '0;
    end else begin
      if (adc_cnt >= div_eff(adc_div) - 8'd1) begin
        adc_cnt <= '0;
        adc_clk <= ~adc_clk;
        if (adc_clk) adc_sample <= adc_data;
      end else begin
        adc_cnt <= adc_cnt + 8'd1;
      end
      if (dac_cnt >= div_eff(dac_div) - 8'd1) begin
        dac_cnt <= '0;
        dac_clk <= ~dac_clk;
        if (!dac_clk) begin
          dac_data <= pattern[dac_ptr];
          dac_ptr  <= dac_ptr + 2'd1;
        end
      end else begin
        dac_cnt <= dac_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge osc_27m or posedge rst_key) begin
    if (rst_key) begin
      ge_q      <= 1'b0;
      trig_lvl  <= 1'b0;
      trig_byte <= 1'b0;
    end else begin
      ge_q      <= ge;
      trig_lvl  <= (trig_mode == 8'd0) ? ge : (ge & ~ge_q);
      trig_byte <= byte_valid;
    end
  end
endmodule

// File: tb/tb_pocket_lab_ctrl.sv
// Randomised bench for pocket_lab_ctrl with a frame-level model.
// Drives SPI frames, measures clocks, DAC sequence and triggers.
`timescale 1ns/1ps
module tb_pocket_lab_ctrl;
  localparam int HALF = 10;
  localparam int GAP  = 100;

  logic       osc_27m = 1'b0;
  logic       rst_key = 1'b1;
  logic       adc_clk;
  logic [7:0] adc_data = 8'h00;
  logic       dac_clk;
  logic [7:0] dac_data;
  logic       spi_clk = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic       spi_cs = 1'b1;
  logic [3:0] triggers;

  pocket_lab_ctrl dut (
    .osc_27m (osc_27m),
    .rst_key (rst_key),
    .adc_clk (adc_clk),
    .adc_data(adc_data),
    .dac_clk (dac_clk),
    .dac_data(dac_data),
    .spi_clk (spi_clk),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .spi_cs  (spi_cs),
    .triggers(triggers)
  );

  always #18.5 osc_27m = ~osc_27m;

  int n_chk = 0;
  int n_pass = 0;
  int n_t0 = 0;
  int n_t1 = 0;
  int n_t2 = 0;
  int n_t3 = 0;

  always @(negedge osc_27m) begin
    if (!rst_key) begin
      n_t0 += int'(triggers[0]);
      n_t1 += int'(triggers[1]);
      n_t2 += int'(triggers[2]);
      n_t3 += int'(triggers[3]);
    end
  end

  // Model state
  int         m_st = 0;
  int         m_idx = 0;
  logic [7:0] m_sh [8];
  logic [7:0] m_lvl = 8'h80;
  logic [7:0] m_mode = 8'h00;
  logic [7:0] m_adc = 8'd2;
  logic [7:0] m_dac = 8'd2;
  logic [7:0] m_pat [4] = '{8'h80, 8'h80, 8'h80, 8'h80};
  logic [7:0] m_tx = 8'hA5;
  int         m_t1 = 0;
  int         m_t2 = 0;
  int         m_t3 = 0;
  logic [7:0] last_adc = 8'h00;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge osc_27m);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) tick();
  endtask

  function automatic int eff(input logic [7:0] d);
    return (d == 8'd0) ? 1 : int'(d);
  endfunction

  function automatic logic [7:0] rnd_nohdr();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    if (b == 8'h5A) b = 8'h00;
    return b;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    m_t3++;
    m_tx = b;
    case (m_st)
      0: if (b == 8'h5A) begin m_st = 1; m_t2++; end
      1: if (b == 8'h01) begin m_st = 2; m_idx = 0; end
         else m_st = 0;
      default: begin
        m_sh[m_idx] = b;
        m_idx++;
        if (m_idx == 8) begin
          m_lvl  = m_sh[0];
          m_mode = m_sh[1];
          m_adc  = m_sh[2];
          m_dac  = m_sh[3];
          for (int i = 0; i < 4; i++) m_pat[i] = m_sh[4+i];
          m_t1++;
          m_st = 0;
        end
      end
    endcase
  endtask

  task automatic spi_byte(input logic [7:0] b);
    logic [7:0] seen;
    for (int i = 0; i < 8; i++) begin
      wait_cyc(HALF);
      seen[i]  = spi_miso;
      spi_clk  = 1'b1;
      spi_mosi = b[i];
      wait_cyc(HALF);
      spi_clk  = 1'b0;
    end
    chk("echo", 32'(seen), 32'(m_tx));
    model_byte(b);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      wait_cyc(HALF);
      spi_clk  = 1'b1;
      spi_mosi = b[i];
      wait_cyc(HALF);
      spi_clk  = 1'b0;
    end
    wait_cyc(GAP);
  endtask

  task automatic send(input logic [7:0] b);
    spi_byte(b);
    wait_cyc(GAP);
  endtask

  task automatic cs_drop();
    spi_cs = 1'b0;
    wait_cyc(20);
    m_st = 0;
    spi_cs = 1'b1;
    wait_cyc(20);
  endtask

  task automatic measure(input bit sel, output int per);
    logic prev, cur;
    int   t0;
    bit   got0;
    per  = -1;
    t0   = 0;
    got0 = 1'b0;
    prev = sel ? dac_clk : adc_clk;
    for (int c = 0; c < 300 && per < 0; c++) begin
      tick();
      cur = sel ? dac_clk : adc_clk;
      if (cur && !prev) begin
        if (!got0) begin got0 = 1'b1; t0 = c; end
        else per = c - t0;
      end
      prev = cur;
    end
  endtask

  task automatic trig_step(input logic [7:0] v);
    int c0;
    adc_data = v;
    c0 = n_t0;
    wait_cyc(40);
    if (m_mode == 8'd0)
      chk("trig_lvl", 32'(triggers[0]), 32'(v >= m_lvl));
    else
      chk("trig_edge", n_t0 - c0,
          (last_adc < m_lvl && v >= m_lvl) ? 1 : 0);
    last_adc = v;
  endtask

  task automatic check_cfg(input bit fresh);
    logic [7:0] d [5];
    logic       prev;
    int         got, per;
    bit         ok, any;
    got  = 0;
    prev = dac_clk;
    for (int k = 0; k < 5; k++) d[k] = 8'hxx;
    for (int c = 0; c < 400 && got < 5; c++) begin
      tick();
      if (dac_clk && !prev) begin d[got] = dac_data; got++; end
      prev = dac_clk;
    end
    chk("dac_rises", got, 5);
    if (fresh) begin
      for (int k = 0; k < 5; k++)
        chk("dac_data", 32'(d[k]), 32'(m_pat[k%4]));
    end else begin
      any = 1'b0;
      for (int r = 0; r < 4; r++) begin
        ok = 1'b1;
        for (int k = 0; k < 5; k++)
          if (d[k] !== m_pat[(r+k)%4]) ok = 1'b0;
        if (ok) any = 1'b1;
      end
      chk("dac_rot", 32'(any), 1);
    end
    measure(1'b0, per);
    chk("adc_per", per, 2 * eff(m_adc));
    measure(1'b1, per);
    chk("dac_per", per, 2 * eff(m_dac));
    chk("cnt_cfg", n_t1, m_t1);
    chk("cnt_hdr", n_t2, m_t2);
    chk("cnt_byte", n_t3, m_t3);
    trig_step((m_lvl == 8'd0) ? 8'd0 : m_lvl - 8'd1);
    trig_step(m_lvl);
    trig_step(8'($urandom_range(0, 255)));
    trig_step(8'($urandom_range(0, 255)));
  endtask

  task automatic wait_apply();
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 80 && !seen; c++) begin
      tick();
      if (triggers[1]) seen = 1'b1;
    end
    chk("apply_seen", 32'(seen), 1);
  endtask

  task automatic send_frame(input logic [7:0] p [8]);
    send(8'h5A);
    send(8'h01);
    for (int i = 0; i < 7; i++) send(p[i]);
    spi_byte(p[7]);
    wait_apply();
    check_cfg(1'b1);
    wait_cyc(GAP);
  endtask

  task automatic rnd_frame(output logic [7:0] p [8]);
    p[0] = 8'($urandom_range(0, 255));
    p[1] = ($urandom_range(0, 1) != 0) ? 8'h00
         : 8'($urandom_range(1, 255));
    p[2] = 8'($urandom_range(0, 6));
    p[3] = 8'($urandom_range(0, 6));
    for (int i = 4; i < 8; i++) p[i] = 8'($urandom_range(0, 255));
  endtask

  logic [7:0] fr [8];

  initial begin
    wait_cyc(3);
    chk("rst_adc_clk", 32'(adc_clk), 0);
    chk("rst_dac_clk", 32'(dac_clk), 0);
    chk("rst_dac_data", 32'(dac_data), 32'h80);
    chk("rst_miso", 32'(spi_miso), 0);
    chk("rst_trig", 32'(triggers), 0);
    rst_key = 1'b0;
    wait_cyc(10);
    check_cfg(1'b0);

    send(8'h00);
    check_cfg(1'b0);

    fr = '{8'hFF, 8'h00, 8'h04, 8'h10,
           8'h00, 8'h01, 8'h02, 8'h03};
    send_frame(fr);

    send(8'h5A);
    send(8'h02);
    for (int i = 0; i < 8; i++) send(rnd_nohdr());
    check_cfg(1'b0);

    send(8'h5A);
    send(8'h01);
    for (int i = 0; i < 3; i++) send(8'($urandom_range(0, 255)));
    cs_drop();
    check_cfg(1'b0);
    rnd_frame(fr);
    send_frame(fr);

    spi_bits(8'h5A, 3);
    chk("partial_cnt", n_t3, m_t3);
    rnd_frame(fr);
    send_frame(fr);

    for (int f = 0; f < 4; f++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--)
        send(rnd_nohdr());
      rnd_frame(fr);
      send_frame(fr);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
